// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store,
// data-first with a fetch starvation guard, one outstanding transaction.
module mem_port_arbiter #(
    parameter int addr_w       = 48,
    parameter int starve_limit = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [addr_w-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic [addr_w-1:0] d_addr,
    input  logic              d_we,
    input  logic [63:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [63:0]       d_rdata,
    output logic              mem_req,
    output logic [addr_w-1:0] mem_addr,
    output logic              mem_we,
    output logic [63:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [63:0]       mem_rdata
);
    localparam int cw = $clog2(starve_limit + 1);
    localparam logic [cw-1:0] lim = cw'(starve_limit);

    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

    state_t        state;
    logic [cw-1:0] starve_cnt;
    logic          kill;
    logic          idle;
    logic          if_win;
    logic          done;

    // Grants are combinational so a request is accepted in its first IDLE cycle.
    always_comb begin
        idle   = !reset && state == IDLE;
        if_win = if_req && (!d_req || starve_cnt >= lim);
        if_gnt = idle && if_win;
        d_gnt  = idle && d_req && !if_win;
        done   = state != IDLE && mem_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            kill       <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            starve_cnt <= (!if_req || if_gnt) ? '0 :
                          (d_gnt && starve_cnt != lim) ? starve_cnt + 1'b1 : starve_cnt;
            if (if_gnt || d_gnt) begin
                state     <= if_gnt ? IF_BUSY : D_BUSY;
                mem_req   <= 1'b1;
                mem_addr  <= if_gnt ? if_addr : d_addr;
                mem_we    <= d_gnt && d_we;
                mem_wdata <= d_wdata;
                kill      <= if_gnt && if_flush;
            end else if (done) begin
                state   <= IDLE;
                mem_req <= 1'b0;
                kill    <= 1'b0;
                if (state == IF_BUSY) begin
                    // A flush on the completing cycle still kills the response.
                    if_rvalid <= !kill && !if_flush;
                    if_rdata  <= mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                end else begin
                    d_rvalid <= 1'b1;
                    if (!mem_we) d_rdata <= mem_rdata;
                end
            end else if (state == IF_BUSY && if_flush) begin
                kill <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a transaction-level reference
// model compared against every output on each falling clock edge.
module tb_mem_port_arbiter;
    localparam int AW = 48;
    localparam int LIMIT = 4;
    localparam logic [63:0] R  = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] R2 = 64'h0F0E_0D0C_0B0A_0908;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [63:0]   d_wdata = '0, mem_rdata = '0;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
    logic [31:0]   if_rdata;
    logic [63:0]   d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    mem_port_arbiter #(.addr_w(AW), .starve_limit(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner 0 = memory idle, 1 = fetch transaction, 2 = data transaction.
    int            m_owner = 0;
    int            m_lost = 0;
    logic [AW-1:0] m_addr = '0;
    logic          m_we = 1'b0, m_kill = 1'b0;
    logic [63:0]   m_wdata = '0, e_d_rdata = '0;
    logic [31:0]   e_if_rdata = '0;
    logic          e_if_rvalid = 1'b0, e_d_rvalid = 1'b0;

    function automatic int winner();
        if (m_owner != 0) return 0;
        if (if_req && d_req) return (m_lost >= LIMIT) ? 1 : 2;
        return if_req ? 1 : d_req ? 2 : 0;
    endfunction

    always @(posedge clk) begin : model
        int w;
        w = winner();
        if (reset) begin
            m_owner = 0; m_lost = 0; m_kill = 0; m_addr = '0; m_we = 0; m_wdata = '0;
            e_if_rvalid = 0; e_d_rvalid = 0; e_if_rdata = '0; e_d_rdata = '0;
        end else begin
            e_if_rvalid = 0;
            e_d_rvalid = 0;
            if (m_owner != 0 && mem_ready) begin
                if (m_owner == 1) begin
                    e_if_rvalid = !m_kill && !if_flush;
                    e_if_rdata = ((m_addr / 4) % 2 == 1) ? mem_rdata[63:32] : mem_rdata[31:0];
                end else begin
                    e_d_rvalid = 1;
                    if (!m_we) e_d_rdata = mem_rdata;
                end
                m_owner = 0;
                m_kill = 0;
            end else if (m_owner == 1 && if_flush) begin
                m_kill = 1;
            end else if (w != 0) begin
                m_owner = w;
                m_addr = (w == 1) ? if_addr : d_addr;
                m_we = (w == 2) && d_we;
                m_wdata = d_wdata;
                m_kill = (w == 1) && if_flush;
            end
            if (!if_req || w == 1) m_lost = 0;
            else if (w == 2 && m_lost < LIMIT) m_lost = m_lost + 1;
        end
    end

    always @(negedge clk) begin : compare
        int w;
        w = reset ? 0 : winner();
        check("if_gnt", if_gnt, w == 1);
        check("d_gnt", d_gnt, w == 2);
        check("mem_req", mem_req, m_owner != 0);
        check("if_rvalid", if_rvalid, e_if_rvalid);
        check("d_rvalid", d_rvalid, e_d_rvalid);
        check("d_rdata", d_rdata, e_d_rdata);
        if (e_if_rvalid) check("if_rdata", if_rdata, e_if_rdata);
        if (m_owner != 0) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_we", mem_we, m_we);
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
        if (reset) begin
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_if_rdata", if_rdata, 0);
        end
    end

    logic [AW-1:0] seen_addr;
    logic          seen_we;
    logic [63:0]   seen_wdata;

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic issue(input bit fetch, input logic [AW-1:0] addr, input logic we, input logic [63:0] wdata);
        int n = 0;
        if (fetch) begin if_req = 1; if_addr = addr; end
        else begin d_req = 1; d_addr = addr; d_we = we; d_wdata = wdata; end
        @(negedge clk);
        while ((fetch ? if_gnt : d_gnt) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("gnt_wait", n < 20, 1);
        step();
        if (fetch) if_req = 0; else d_req = 0;
    endtask

    task automatic finish_txn(input int k, input logic [63:0] rdata);
        for (int i = 1; i <= k; i++) begin
            mem_ready = (i == k);
            mem_rdata = rdata;
            if (i == 1) begin
                @(negedge clk);
                seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata;
            end
            step();
        end
        mem_ready = 0;
    endtask

    initial begin : stim
        logic [9:0] pattern, expect_pattern;
        int cnt;
        pattern = '0;
        expect_pattern = 10'b10_0001_0000;
        step(); step();
        reset = 0;

        // Load @0x100, ready two cycles after mem_req.
        issue(0, 48'h100, 0, 0);
        finish_txn(2, R);
        @(negedge clk);
        check("t1_d_rvalid", d_rvalid, 1);
        check("t1_d_rdata", d_rdata, 64'hDEADBEEF01234567);
        check("t1_mem_req_low", mem_req, 0);
        step();

        // Fetch word selection by address bit 2.
        issue(1, 48'h104, 0, 0);
        finish_txn(1, R);
        @(negedge clk);
        check("t2_if_rvalid", if_rvalid, 1);
        check("t2_if_rdata_hi", if_rdata, 32'hDEADBEEF);
        step();
        issue(1, 48'h100, 0, 0);
        finish_txn(3, R);
        @(negedge clk);
        check("t2_mem_we", seen_we, 0);
        check("t2_if_rdata_lo", if_rdata, 32'h01234567);
        step();

        // Both sides requesting continuously: data wins four times, then fetch.
        if_req = 1; if_addr = 48'h108; d_req = 1; d_addr = 48'h300; d_we = 0; mem_ready = 1; mem_rdata = R;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 10; c++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                pattern[cnt] = if_gnt;
                cnt++;
            end
        end
        step();
        if_req = 0; d_req = 0;
        step();
        mem_ready = 0;
        check("t3_grant_count", cnt, 10);
        check("t3_grant_order", pattern, expect_pattern);
        step();

        // Store: d_rdata keeps the last load value.
        issue(0, 48'h200, 1, 64'h55);
        finish_txn(2, R2);
        @(negedge clk);
        check("t4_mem_we", seen_we, 1);
        check("t4_mem_wdata", seen_wdata, 64'h55);
        check("t4_mem_addr", seen_addr, 48'h200);
        check("t4_d_rvalid", d_rvalid, 1);
        check("t4_d_rdata_kept", d_rdata, 64'hDEADBEEF01234567);
        check("t4_if_rvalid", if_rvalid, 0);
        step();

        // Flush one cycle after grant; memory still completes, response dropped.
        issue(1, 48'h110, 0, 0);
        if_flush = 1;
        step();
        if_flush = 0;
        step();
        mem_ready = 1; mem_rdata = R;
        step();
        mem_ready = 0; if_req = 1; if_addr = 48'h114;
        @(negedge clk);
        check("t5_no_rvalid", if_rvalid, 0);
        check("t5_refetch_gnt", if_gnt, 1);
        step();
        if_req = 0;
        finish_txn(1, R);
        @(negedge clk);
        check("t5_refetch_rvalid", if_rvalid, 1);
        check("t5_refetch_rdata", if_rdata, 32'hDEADBEEF);
        step();

        // Flush in the grant cycle also kills the response; flush during data is ignored.
        if_flush = 1;
        issue(1, 48'h118, 0, 0);
        if_flush = 0;
        finish_txn(1, R);
        @(negedge clk);
        check("flush_at_gnt", if_rvalid, 0);
        step();
        issue(0, 48'h120, 0, 0);
        if_flush = 1;
        finish_txn(2, R2);
        if_flush = 0;
        @(negedge clk);
        check("flush_in_d_busy", d_rdata, R2);
        step();

        // Asynchronous reset during an outstanding transaction.
        issue(0, 48'h180, 0, 0);
        d_req = 1; d_addr = 48'h1C0;
        @(negedge clk);
        check("t6_busy", mem_req, 1);
        #2 reset = 1;
        #1;
        check("t6_async_mem_req", mem_req, 0);
        check("t6_async_mem_addr", mem_addr, 0);
        check("t6_async_d_gnt", d_gnt, 0);
        check("t6_async_d_rdata", d_rdata, 0);
        step(); step();
        reset = 0;
        @(negedge clk);
        check("t6_first_gnt", d_gnt, 1);
        step();
        d_req = 0;
        finish_txn(1, R);
        @(negedge clk);
        check("t6_rvalid", d_rvalid, 1);
        check("t6_rdata", d_rdata, R);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
